// File: rtl/projectile_pkg.sv
// Purpose: shared types, playfield constants and the bound test for the
//          projectile pool.
// Contents: slot_state_t, vel_t (signed 8b), pos_ext_t (signed 12b),
//           geometry localparams, out_of_bounds().
package projectile_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, FLIGHT = 1'b1} slot_state_t;

  typedef logic signed [7:0]  vel_t;
  typedef logic signed [11:0] pos_ext_t;

  localparam int unsigned POS_W = 10;
  localparam int unsigned AGE_W = 8;

  localparam int VX_BASE = 7;
  localparam int GRAVITY = 1;
  localparam int VY_MAX  = 15;
  localparam int OFF_X   = 35;
  localparam int OFF_Y   = 15;
  localparam int SIZE    = 3;
  localparam int X_MIN   = 0;
  localparam int X_MAX   = 639;
  localparam int Y_MIN   = 0;
  localparam int Y_MAX   = 479;

  // True when a bullet centred at (nx, ny) touches or crosses any playfield edge.
  function automatic logic out_of_bounds(input pos_ext_t nx, input pos_ext_t ny);
    return (nx - pos_ext_t'(SIZE) <= pos_ext_t'(X_MIN)) ||
           (nx + pos_ext_t'(SIZE) >= pos_ext_t'(X_MAX)) ||
           (ny - pos_ext_t'(SIZE) <= pos_ext_t'(Y_MIN)) ||
           (ny + pos_ext_t'(SIZE) >= pos_ext_t'(Y_MAX));
  endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// Purpose: bundle between tank controller / renderer (master) and the
//          projectile pool (slave).
// Signals: clear, fire, tank_x/y, dir, power, vy_init toward the pool;
//          bullet_x/y (packed, 10b per slot), active, fire_ack, fire_drop,
//          expire_pulse from the pool.
interface projectile_pool_if #(parameter int unsigned N_SLOTS = 4);
  import projectile_pkg::*;

  logic                     clear;
  logic                     fire;
  logic [POS_W-1:0]         tank_x;
  logic [POS_W-1:0]         tank_y;
  logic                     dir;
  logic [1:0]               power;
  vel_t                     vy_init;
  logic [POS_W*N_SLOTS-1:0] bullet_x;
  logic [POS_W*N_SLOTS-1:0] bullet_y;
  logic [N_SLOTS-1:0]       active;
  logic                     fire_ack;
  logic                     fire_drop;
  logic [N_SLOTS-1:0]       expire_pulse;

  modport master (
    output clear, fire, tank_x, tank_y, dir, power, vy_init,
    input  bullet_x, bullet_y, active, fire_ack, fire_drop, expire_pulse
  );

  modport slave (
    input  clear, fire, tank_x, tank_y, dir, power, vy_init,
    output bullet_x, bullet_y, active, fire_ack, fire_drop, expire_pulse
  );

endinterface

// File: rtl/projectile_slot.sv
// Purpose: one bullet: IDLE/FLIGHT state, kinematics, gravity with vy
//          saturation, lifetime counter and kill test.
// Ports: clk, rst_n, clear_i, launch_i + launch_{x,y,vx,vy}_i in;
//        active_o, x_o, y_o, expire_o (all registered) out.
module projectile_slot
  import projectile_pkg::*;
#(
  parameter int unsigned LIFETIME = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             launch_i,
  input  logic [POS_W-1:0] launch_x_i,
  input  logic [POS_W-1:0] launch_y_i,
  input  vel_t             launch_vx_i,
  input  vel_t             launch_vy_i,
  output logic             active_o,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o,
  output logic             expire_o
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_FLIGHT = FLIGHT;

  logic [0:0]       state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  vel_t             vx_q, vx_d, vy_q, vy_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             expire_q, expire_d;

  pos_ext_t          nx_c, ny_c;
  logic signed [8:0] vy_inc_c;
  vel_t              vy_sat_c;
  logic [AGE_W-1:0]  age_inc_c;
  logic              kill_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      age_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      age_q    <= age_d;
      expire_q <= expire_d;
    end
  end

  // Next state: clear beats launch beats flight step
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    age_d    = age_q;
    expire_d = 1'b0;

    // 12-bit signed so a step past 0 or 1023 is still caught by the bound test
    nx_c      = pos_ext_t'({2'b00, x_q}) + pos_ext_t'(vx_q);
    ny_c      = pos_ext_t'({2'b00, y_q}) + pos_ext_t'(vy_q);
    vy_inc_c  = 9'(vy_q) + 9'(GRAVITY);
    vy_sat_c  = (vy_inc_c > 9'(VY_MAX)) ? vel_t'(VY_MAX) : vel_t'(vy_inc_c);
    age_inc_c = age_q + AGE_W'(1);
    kill_c    = out_of_bounds(nx_c, ny_c) || (age_inc_c == AGE_W'(LIFETIME));

    if (clear_i) begin
      state_d = ST_IDLE;
    end else if (launch_i) begin
      state_d = ST_FLIGHT;
      x_d     = launch_x_i;
      y_d     = launch_y_i;
      vx_d    = launch_vx_i;
      vy_d    = launch_vy_i;
      age_d   = '0;
    end else if (state_q == ST_FLIGHT) begin
      if (kill_c) begin
        // Position holds at the last in-bound value
        state_d  = ST_IDLE;
        expire_d = 1'b1;
      end else begin
        x_d   = nx_c[POS_W-1:0];
        y_d   = ny_c[POS_W-1:0];
        vy_d  = vy_sat_c;
        age_d = age_inc_c;
      end
    end
  end

  assign active_o = (state_q == ST_FLIGHT);
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign expire_o = expire_q;

endmodule

// File: rtl/projectile_pool.sv
// Purpose: N-slot projectile engine: fire edge detect, cooldown, lowest-index
//          idle-slot allocation, slot array and output packing.
// Ports: frame_clk, Reset_n (async, active-low), bus (projectile_pool_if.slave).
module projectile_pool
  import projectile_pkg::*;
#(
  parameter int unsigned N_SLOTS  = 4,
  parameter int unsigned LIFETIME = 255,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  projectile_pool_if.slave     bus
);

  localparam int unsigned CD_W = $clog2(COOLDOWN + 2);

  logic             fire_q;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             ack_q, drop_q;

  logic             fire_e_c, accept_c, launch_c, drop_c, found_c;
  logic [N_SLOTS-1:0] sel_c;
  logic [N_SLOTS-1:0] slot_active, slot_expire;
  logic [POS_W-1:0] slot_x [N_SLOTS];
  logic [POS_W-1:0] slot_y [N_SLOTS];
  logic [POS_W-1:0] launch_x_c, launch_y_c;
  vel_t             speed_c, launch_vx_c;

  // Edge detector, cooldown and handshake pulses
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q <= 1'b0;
      cd_q   <= '0;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      fire_q <= bus.fire;
      cd_q   <= cd_d;
      ack_q  <= launch_c;
      drop_q <= drop_c;
    end
  end

  // Accept decision, priority allocator and cooldown next value
  always_comb begin
    fire_e_c = bus.fire & ~fire_q;
    accept_c = fire_e_c & (cd_q == '0) & ~bus.clear;
    launch_c = accept_c & ~(&slot_active);
    drop_c   = accept_c & (&slot_active);

    sel_c   = '0;
    found_c = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (!found_c && !slot_active[k]) begin
        sel_c[k] = 1'b1;
        found_c  = 1'b1;
      end
    end

    cd_d = cd_q;
    if (bus.clear)          cd_d = '0;
    else if (launch_c)      cd_d = CD_W'(COOLDOWN);
    else if (cd_q != '0)    cd_d = cd_q - CD_W'(1);
  end

  // Launch parameters sampled from the tank at fire time
  always_comb begin
    launch_x_c  = bus.tank_x + POS_W'(OFF_X);
    launch_y_c  = bus.tank_y + POS_W'(OFF_Y);
    speed_c     = vel_t'(VX_BASE) + vel_t'({bus.power, 1'b0});
    launch_vx_c = bus.dir ? speed_c : -speed_c;
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    projectile_slot #(.LIFETIME(LIFETIME)) u_slot (
      .clk         (frame_clk),
      .rst_n       (Reset_n),
      .clear_i     (bus.clear),
      .launch_i    (launch_c & sel_c[k]),
      .launch_x_i  (launch_x_c),
      .launch_y_i  (launch_y_c),
      .launch_vx_i (launch_vx_c),
      .launch_vy_i (bus.vy_init),
      .active_o    (slot_active[k]),
      .x_o         (slot_x[k]),
      .y_o         (slot_y[k]),
      .expire_o    (slot_expire[k])
    );
    assign bus.bullet_x[POS_W*k +: POS_W] = slot_x[k];
    assign bus.bullet_y[POS_W*k +: POS_W] = slot_y[k];
  end

  assign bus.active       = slot_active;
  assign bus.expire_pulse = slot_expire;
  assign bus.fire_ack     = ack_q;
  assign bus.fire_drop    = drop_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench: dut uses default parameters, dut2 uses COOLDOWN=0, LIFETIME=20.
module tb_projectile_pool;

  logic frame_clk;
  logic Reset_n;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_act [5];

  projectile_pool_if #(.N_SLOTS(4)) bus ();
  projectile_pool_if #(.N_SLOTS(4)) bus2 ();

  projectile_pool #(.N_SLOTS(4)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  projectile_pool #(.N_SLOTS(4), .LIFETIME(20), .COOLDOWN(0)) dut2 (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic nstep(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.clear = 1'b0;  bus.fire = 1'b0;  bus.tank_x = '0;  bus.tank_y = '0;
    bus.dir = 1'b0;    bus.power = '0;   bus.vy_init = '0;
    bus2.clear = 1'b0; bus2.fire = 1'b0; bus2.tank_x = '0; bus2.tank_y = '0;
    bus2.dir = 1'b0;   bus2.power = '0;  bus2.vy_init = '0;
    exp_act = '{64'd1, 64'd3, 64'd7, 64'd15, 64'd15};

    // Reset state
    nstep(1);
    chk("rst_active", 64'(bus.active), 64'd0);
    chk("rst_bx", 64'(bus.bullet_x), 64'd0);
    chk("rst_by", 64'(bus.bullet_y), 64'd0);
    chk("rst_ack", 64'(bus.fire_ack), 64'd0);
    chk("rst_exp", 64'(bus.expire_pulse), 64'd0);
    Reset_n = 1'b1;
    nstep(1);

    // Basic launch
    bus.tank_x = 10'd100; bus.tank_y = 10'd200; bus.dir = 1'b1;
    bus.power = 2'd0; bus.vy_init = -8'sd4; bus.fire = 1'b1;
    nstep(1);
    chk("launch_ack", 64'(bus.fire_ack), 64'd1);
    chk("launch_active", 64'(bus.active), 64'd1);
    chk("launch_x0", 64'(bus.bullet_x[9:0]), 64'd135);
    chk("launch_y0", 64'(bus.bullet_y[9:0]), 64'd215);
    bus.fire = 1'b0;
    nstep(1);
    chk("step1_x0", 64'(bus.bullet_x[9:0]), 64'd142);
    chk("step1_y0", 64'(bus.bullet_y[9:0]), 64'd211);
    chk("step1_ack", 64'(bus.fire_ack), 64'd0);
    nstep(1);
    chk("step2_x0", 64'(bus.bullet_x[9:0]), 64'd149);
    chk("step2_y0", 64'(bus.bullet_y[9:0]), 64'd208);

    // Clear with a simultaneous fire edge (cooldown expired)
    nstep(7);
    bus.clear = 1'b1; bus.fire = 1'b1;
    nstep(1);
    chk("clr_active", 64'(bus.active), 64'd0);
    chk("clr_ack", 64'(bus.fire_ack), 64'd0);
    chk("clr_drop", 64'(bus.fire_drop), 64'd0);
    chk("clr_exp", 64'(bus.expire_pulse), 64'd0);
    bus.clear = 1'b0; bus.fire = 1'b0;
    nstep(1);

    // Cooldown: edges at cycles 0, 4 (ignored), 10 (slot1)
    bus.vy_init = 8'sd0; bus.fire = 1'b1;
    nstep(1);
    chk("cd0_ack", 64'(bus.fire_ack), 64'd1);
    bus.fire = 1'b0;
    nstep(3);
    bus.fire = 1'b1;
    nstep(1);
    chk("cd4_ack", 64'(bus.fire_ack), 64'd0);
    chk("cd4_drop", 64'(bus.fire_drop), 64'd0);
    chk("cd4_active", 64'(bus.active), 64'd1);
    bus.fire = 1'b0;
    nstep(5);
    bus.fire = 1'b1;
    nstep(1);
    chk("cd10_ack", 64'(bus.fire_ack), 64'd1);
    chk("cd10_active", 64'(bus.active), 64'd3);
    chk("cd10_x1", 64'(bus.bullet_x[19:10]), 64'd135);
    bus.fire = 1'b0; bus.clear = 1'b1;
    nstep(1);
    chk("clr2_active", 64'(bus.active), 64'd0);
    chk("clr2_exp", 64'(bus.expire_pulse), 64'd0);
    bus.clear = 1'b0;

    // Right boundary: launch x=625, next nx=638 hits the edge
    bus.tank_x = 10'd590; bus.power = 2'd3; bus.fire = 1'b1;
    nstep(1);
    chk("bnd_ack", 64'(bus.fire_ack), 64'd1);
    chk("bnd_x0", 64'(bus.bullet_x[9:0]), 64'd625);
    bus.fire = 1'b0;
    nstep(1);
    chk("bnd_exp", 64'(bus.expire_pulse), 64'd1);
    chk("bnd_active", 64'(bus.active), 64'd0);
    chk("bnd_hold_x0", 64'(bus.bullet_x[9:0]), 64'd625);
    nstep(1);
    chk("bnd_exp_off", 64'(bus.expire_pulse), 64'd0);

    // Asynchronous reset mid-flight
    nstep(7);
    bus.tank_x = 10'd100; bus.power = 2'd0; bus.fire = 1'b1;
    nstep(1);
    chk("pre_rst_ack", 64'(bus.fire_ack), 64'd1);
    bus.fire = 1'b0;
    nstep(1);
    chk("pre_rst_active", 64'(bus.active), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_active", 64'(bus.active), 64'd0);
    chk("async_rst_bx", 64'(bus.bullet_x), 64'd0);
    chk("async_rst_by", 64'(bus.bullet_y), 64'd0);
    nstep(1);
    Reset_n = 1'b1;
    nstep(1);

    // Left edge with a step below zero: 35 -> 22 -> 9 -> (-4) kill
    bus.tank_x = 10'd0; bus.dir = 1'b0; bus.power = 2'd3; bus.fire = 1'b1;
    nstep(1);
    chk("left_x0", 64'(bus.bullet_x[9:0]), 64'd35);
    bus.fire = 1'b0;
    nstep(2);
    chk("left_x0_s2", 64'(bus.bullet_x[9:0]), 64'd9);
    chk("left_active_s2", 64'(bus.active), 64'd1);
    nstep(1);
    chk("left_exp", 64'(bus.expire_pulse), 64'd1);
    chk("left_hold_x0", 64'(bus.bullet_x[9:0]), 64'd9);

    // Allocation and drop on dut2 (no cooldown)
    bus2.tank_x = 10'd100; bus2.tank_y = 10'd200; bus2.dir = 1'b1;
    bus2.power = 2'd0; bus2.vy_init = 8'sd0;
    for (int i = 0; i < 5; i++) begin
      bus2.fire = 1'b1;
      nstep(1);
      chk($sformatf("alloc%0d_active", i), 64'(bus2.active), exp_act[i]);
      chk($sformatf("alloc%0d_ack", i), 64'(bus2.fire_ack), (i < 4) ? 64'd1 : 64'd0);
      chk($sformatf("alloc%0d_drop", i), 64'(bus2.fire_drop), (i < 4) ? 64'd0 : 64'd1);
      bus2.fire = 1'b0;
      nstep(1);
    end
    chk("drop_off", 64'(bus2.fire_drop), 64'd0);
    bus2.clear = 1'b1;
    nstep(1);
    chk("clr3_active", 64'(bus2.active), 64'd0);
    bus2.clear = 1'b0;

    // vy saturation: vy_init=14 gives steps +14, +15, +15
    bus2.tank_y = 10'd85; bus2.vy_init = 8'sd14; bus2.fire = 1'b1;
    nstep(1);
    chk("sat_y0", 64'(bus2.bullet_y[9:0]), 64'd100);
    bus2.fire = 1'b0;
    nstep(1);
    chk("sat_y1", 64'(bus2.bullet_y[9:0]), 64'd114);
    nstep(1);
    chk("sat_y2", 64'(bus2.bullet_y[9:0]), 64'd129);
    nstep(1);
    chk("sat_y3", 64'(bus2.bullet_y[9:0]), 64'd144);
    bus2.clear = 1'b1;
    nstep(1);
    bus2.clear = 1'b0;

    // Lifetime 20 from y=300, vy_init=-8
    bus2.tank_y = 10'd285; bus2.vy_init = -8'sd8; bus2.fire = 1'b1;
    nstep(1);
    chk("life_y0", 64'(bus2.bullet_y[9:0]), 64'd300);
    bus2.fire = 1'b0;
    nstep(19);
    chk("life19_active", 64'(bus2.active), 64'd1);
    chk("life19_exp", 64'(bus2.expire_pulse), 64'd0);
    chk("life19_y0", 64'(bus2.bullet_y[9:0]), 64'd319);
    chk("life19_x0", 64'(bus2.bullet_x[9:0]), 64'd268);
    nstep(1);
    chk("life20_exp", 64'(bus2.expire_pulse), 64'd1);
    chk("life20_active", 64'(bus2.active), 64'd0);
    chk("life20_hold_y0", 64'(bus2.bullet_y[9:0]), 64'd319);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
